// File: rtl/ula_video_timing.sv
// Spectrum ULA raster timing: pixel/line counters plus registered sync, blank, display,
// irq, flash and frame decodes; 48K/128K geometry is latched only at the frame wrap.
module ula_video_timing #(
  parameter int HBLANK_START = 320,
  parameter int HSYNC_START  = 344,
  parameter int HSYNC_END    = 376,
  parameter int HBLANK_END   = 416,
  parameter int VBLANK_START = 248,
  parameter int VSYNC_START  = 248,
  parameter int VSYNC_END    = 252,
  parameter int VBLANK_END   = 256,
  parameter int LINE_48      = 448,
  parameter int LINES_48     = 312,
  parameter int LINE_128     = 456,
  parameter int LINES_128    = 311,
  parameter int IRQ_LEN_48   = 64,
  parameter int IRQ_LEN_128  = 72,
  parameter int DISPLAY_W    = 256,
  parameter int DISPLAY_H    = 192
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pe7M0,
  input  logic       model,
  output logic [8:0] hCount,
  output logic [8:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       blank,
  output logic       display,
  output logic       irq,
  output logic       flash,
  output logic       frame
);

  localparam logic [8:0] C_HBS       = 9'(HBLANK_START);
  localparam logic [8:0] C_HSS       = 9'(HSYNC_START);
  localparam logic [8:0] C_HSE       = 9'(HSYNC_END);
  localparam logic [8:0] C_HBE       = 9'(HBLANK_END);
  localparam logic [8:0] C_VBS       = 9'(VBLANK_START);
  localparam logic [8:0] C_VSS       = 9'(VSYNC_START);
  localparam logic [8:0] C_VSE       = 9'(VSYNC_END);
  localparam logic [8:0] C_VBE       = 9'(VBLANK_END);
  localparam logic [8:0] C_HLAST_48  = 9'(LINE_48 - 1);
  localparam logic [8:0] C_VLAST_48  = 9'(LINES_48 - 1);
  localparam logic [8:0] C_HLAST_128 = 9'(LINE_128 - 1);
  localparam logic [8:0] C_VLAST_128 = 9'(LINES_128 - 1);
  localparam logic [8:0] C_IRQ_48    = 9'(IRQ_LEN_48);
  localparam logic [8:0] C_IRQ_128   = 9'(IRQ_LEN_128);
  localparam logic [8:0] C_DW        = 9'(DISPLAY_W);
  localparam logic [8:0] C_DH        = 9'(DISPLAY_H);

  logic [8:0] r_hCount;
  logic [8:0] r_vCount;
  logic       r_hSync;
  logic       r_vSync;
  logic       r_blank;
  logic       r_display;
  logic       r_irq;
  logic       r_frame;
  logic       r_model;
  logic [4:0] r_flashCnt;

  logic [8:0] w_hLast;
  logic [8:0] w_vLast;
  logic [8:0] w_hNext;
  logic [8:0] w_vNext;
  logic [8:0] w_irqLen;
  logic       w_lineWrap;
  logic       w_frameWrap;
  logic       w_modelNext;

  assign w_hLast     = r_model ? C_HLAST_128 : C_HLAST_48;
  assign w_vLast     = r_model ? C_VLAST_128 : C_VLAST_48;
  assign w_lineWrap  = pe7M0 && (r_hCount == w_hLast);
  assign w_frameWrap = w_lineWrap && (r_vCount == w_vLast);
  assign w_hNext     = !pe7M0 ? r_hCount : (w_lineWrap ? 9'd0 : r_hCount + 9'd1);
  assign w_vNext     = !w_lineWrap ? r_vCount : (w_frameWrap ? 9'd0 : r_vCount + 9'd1);
  assign w_modelNext = w_frameWrap ? model : r_model;
  assign w_irqLen    = w_modelNext ? C_IRQ_128 : C_IRQ_48;

  // Decodes use next-state counters so they line up with the counters they accompany.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hCount   <= 9'd0;
      r_vCount   <= 9'd0;
      r_hSync    <= 1'b0;
      r_vSync    <= 1'b0;
      r_blank    <= 1'b0;
      r_display  <= 1'b1;
      r_irq      <= 1'b1;
      r_frame    <= 1'b0;
      r_model    <= 1'b0;
      r_flashCnt <= 5'd0;
    end else begin
      r_hCount  <= w_hNext;
      r_vCount  <= w_vNext;
      r_model   <= w_modelNext;
      r_frame   <= w_frameWrap;
      if (w_frameWrap) begin
        r_flashCnt <= r_flashCnt + 5'd1;
      end
      r_hSync   <= (w_hNext >= C_HSS) && (w_hNext < C_HSE);
      r_vSync   <= (w_vNext >= C_VSS) && (w_vNext < C_VSE);
      r_blank   <= ((w_hNext >= C_HBS) && (w_hNext < C_HBE)) ||
                   ((w_vNext >= C_VBS) && (w_vNext < C_VBE));
      r_display <= (w_hNext < C_DW) && (w_vNext < C_DH);
      r_irq     <= !((w_vNext == C_VBS) && (w_hNext < w_irqLen));
    end
  end

  assign hCount  = r_hCount;
  assign vCount  = r_vCount;
  assign hSync   = r_hSync;
  assign vSync   = r_vSync;
  assign blank   = r_blank;
  assign display = r_display;
  assign irq     = r_irq;
  assign flash   = r_flashCnt[4];
  assign frame   = r_frame;

endmodule
